rec2pol_arbiter: RTL and testbench

- Shares one iterative rec2pol (rectangular-to-polar CORDIC) unit between N requesters, e.g. several Hilbert-filter I/Q channels.
- Arbitrates requests round-robin and latches the winner's operands.
- Pulses the unit's start input and waits a fixed latency.
- Captures modulus and angle, then returns them tagged with the requester id.

---
 rtl/rec2pol_pkg.sv | 15 +
 rtl/rec2pol_arbiter_if.sv | 35 +++
 rtl/rec2pol_arbiter_rr_picker.sv | 41 ++++
 rtl/rec2pol_arbiter.sv | 148 ++++++++++++++
 tb/tb_rec2pol_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rec2pol_pkg.sv
// Shared definitions for the rec2pol arbiter slice: FSM encoding and default widths.
package rec2pol_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEF_LATENCY = 33;
   localparam int DEF_DW      = 16;
   localparam int DEF_RW      = 32;

endpackage

// File: rtl/rec2pol_arbiter_if.sv
// Bundle of requester, rec2pol unit and result signals around the shared arbiter.
interface rec2pol_arbiter_if
   import rec2pol_pkg::*;
#(
   parameter int N   = 4,
   parameter int DW  = DEF_DW,
   parameter int RW  = DEF_RW,
   parameter int IDW = 2
);
   logic [N-1:0]    req;
   logic [N*DW-1:0] x_in;
   logic [N*DW-1:0] y_in;
   logic [N-1:0]    gnt;
   logic            r2p_start;
   logic [DW-1:0]   r2p_x;
   logic [DW-1:0]   r2p_y;
   logic [RW-1:0]   r2p_mod;
   logic [RW-1:0]   r2p_angle;
   logic            out_valid;
   logic [IDW-1:0]  out_id;
   logic [RW-1:0]   out_mod;
   logic [RW-1:0]   out_angle;
   logic            busy;

   modport slave (
      input  req, x_in, y_in, r2p_mod, r2p_angle,
      output gnt, r2p_start, r2p_x, r2p_y, out_valid, out_id, out_mod, out_angle, busy
   );

   modport master (
      output req, x_in, y_in, r2p_mod, r2p_angle,
      input  gnt, r2p_start, r2p_x, r2p_y, out_valid, out_id, out_mod, out_angle, busy
   );

endinterface

// File: rtl/rec2pol_arbiter_rr_picker.sv
// Combinational round-robin select: first set req bit at or above ptr, wrapping modulo N.
module rr_picker
   import rec2pol_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   onehot,
   output logic [IDW-1:0] id,
   output logic           any
);

   assign any = |req;

   // Wrap by subtraction so non-power-of-two N never yields an out-of-range index.
   always_comb begin : pick
      logic [IDW:0]   sum;
      logic [IDW-1:0] sel;
      logic           found;
      onehot = '0;
      id     = '0;
      found  = 1'b0;
      sum    = '0;
      sel    = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(N)) begin
            sum = sum - (IDW+1)'(N);
         end
         sel = sum[IDW-1:0];
         if (!found && req[sel]) begin
            found       = 1'b1;
            onehot[sel] = 1'b1;
            id          = sel;
         end
      end
   end

endmodule

// File: rtl/rec2pol_arbiter.sv
// Shares one iterative rec2pol unit between N requesters; round-robin grant,
// fixed-latency wait, result returned tagged with the requester id.
//
//   state | meaning
//   IDLE  | waiting for any req; arbitrates and latches winner operands
//   START | gnt + r2p_start pulse, pointer advances, counter loaded with 1
//   RUN   | counting to LATENCY, then capture r2p_mod/r2p_angle
//   DONE  | out_valid strobe; arbitrates again exactly like IDLE
module rec2pol_arbiter
   import rec2pol_pkg::*;
#(
   parameter int N       = 4,
   parameter int DW      = DEF_DW,
   parameter int RW      = DEF_RW,
   parameter int LATENCY = DEF_LATENCY,
   parameter int IDW     = 2
) (
   input  logic             clock,
   input  logic             reset,
   rec2pol_arbiter_if.slave bus
);

   localparam int CW = $clog2(LATENCY + 1);

   state_t         state, state_nx;
   logic [IDW-1:0] ptr, ptr_nx;
   logic [IDW-1:0] id_q, id_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   logic [N-1:0]   gnt_q, gnt_nx;
   logic           start_q, start_nx;
   logic [DW-1:0]  x_q, x_nx;
   logic [DW-1:0]  y_q, y_nx;
   logic           valid_q, valid_nx;
   logic [IDW-1:0] oid_q, oid_nx;
   logic [RW-1:0]  mod_q, mod_nx;
   logic [RW-1:0]  ang_q, ang_nx;

   logic [N-1:0]   pick_onehot;
   logic [IDW-1:0] pick_id;
   logic           pick_any;

   logic [DW-1:0]  x_slice [N];
   logic [DW-1:0]  y_slice [N];

   for (genvar i = 0; i < N; i++) begin : g_slice
      assign x_slice[i] = bus.x_in[i*DW +: DW];
      assign y_slice[i] = bus.y_in[i*DW +: DW];
   end

   rr_picker #(
      .N   (N),
      .IDW (IDW)
   ) u_picker (
      .req    (bus.req),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .id     (pick_id),
      .any    (pick_any)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= '0;
         id_q    <= '0;
         cnt     <= '0;
         gnt_q   <= '0;
         start_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
         oid_q   <= '0;
         mod_q   <= '0;
         ang_q   <= '0;
      end else begin
         state   <= state_nx;
         ptr     <= ptr_nx;
         id_q    <= id_nx;
         cnt     <= cnt_nx;
         gnt_q   <= gnt_nx;
         start_q <= start_nx;
         x_q     <= x_nx;
         y_q     <= y_nx;
         valid_q <= valid_nx;
         oid_q   <= oid_nx;
         mod_q   <= mod_nx;
         ang_q   <= ang_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      id_nx    = id_q;
      cnt_nx   = cnt;
      gnt_nx   = '0;
      start_nx = 1'b0;
      x_nx     = x_q;
      y_nx     = y_q;
      valid_nx = 1'b0;
      oid_nx   = oid_q;
      mod_nx   = mod_q;
      ang_nx   = ang_q;

      unique case (state)
         IDLE, DONE: begin
            state_nx = IDLE;
            // gnt/start are registered here so they appear during START.
            if (pick_any) begin
               x_nx     = x_slice[pick_id];
               y_nx     = y_slice[pick_id];
               id_nx    = pick_id;
               gnt_nx   = pick_onehot;
               start_nx = 1'b1;
               state_nx = START;
            end
         end
         START: begin
            ptr_nx   = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
            cnt_nx   = CW'(1);
            state_nx = RUN;
         end
         RUN: begin
            if (cnt == CW'(LATENCY)) begin
               mod_nx   = bus.r2p_mod;
               ang_nx   = bus.r2p_angle;
               oid_nx   = id_q;
               valid_nx = 1'b1;
               state_nx = DONE;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.gnt       = gnt_q;
   assign bus.r2p_start = start_q;
   assign bus.r2p_x     = x_q;
   assign bus.r2p_y     = y_q;
   assign bus.out_valid = valid_q;
   assign bus.out_id    = oid_q;
   assign bus.out_mod   = mod_q;
   assign bus.out_angle = ang_q;
   assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_rec2pol_arbiter.sv
// Bench for rec2pol_arbiter: transaction-level model plus stub rec2pol unit,
// directed scenarios, randomized traffic, and a short-latency two-requester instance.
module tb_rec2pol_arbiter;
   import rec2pol_pkg::*;

   localparam int N   = 4;
   localparam int DW  = 16;
   localparam int RW  = 32;
   localparam int L   = 33;
   localparam int IDW = 2;
   localparam int N2  = 2;
   localparam int L2  = 5;

   logic clock  = 1'b0;
   logic reset  = 1'b1;
   logic reset2 = 1'b1;
   always #5 clock = ~clock;

   rec2pol_arbiter_if #(.N(N),  .DW(DW), .RW(RW), .IDW(IDW)) bif  ();
   rec2pol_arbiter_if #(.N(N2), .DW(DW), .RW(RW), .IDW(1))   bif2 ();

   rec2pol_arbiter #(.N(N), .DW(DW), .RW(RW), .LATENCY(L), .IDW(IDW)) dut (
      .clock (clock), .reset (reset), .bus (bif));
   rec2pol_arbiter #(.N(N2), .DW(DW), .RW(RW), .LATENCY(L2), .IDW(1)) dut2 (
      .clock (clock), .reset (reset2), .bus (bif2));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [RW-1:0] stub_mod(input logic [DW-1:0] x, input logic [DW-1:0] y);
      int a, b;
      a = int'($signed(x));
      b = int'($signed(y));
      if (a < 0) a = -a;
      if (b < 0) b = -b;
      return RW'(a + b);
   endfunction

   function automatic logic [RW-1:0] stub_ang(input int id);
      return {16'hA5C0, 16'(id)};
   endfunction

   function automatic int oh2id(input logic [7:0] g);
      for (int i = 0; i < 8; i++) if (g[i]) return i;
      return -1;
   endfunction

   function automatic int qget(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   // stub rec2pol units: result only valid in the single cycle start+LATENCY
   int            s_due = -1, s2_due = -1;
   logic [RW-1:0] s_mod, s_ang, s2_mod, s2_ang;

   // observation logs of the main DUT
   int            g_cyc[$], g_id[$], v_cyc[$], v_id[$];
   logic [RW-1:0] v_mod[$];

   // transaction-level model of the main DUT
   logic          m_on = 1'b0;
   int            m_arb, m_start = -1, m_done = -1, m_ptr = 0;
   int            p_id = 0;
   logic [DW-1:0] p_x, p_y, e_x, e_y;
   logic [RW-1:0] p_mod, p_ang, e_mod, e_ang;
   int            e_id;

   // short-latency instance tracking
   int            g2_last = -1, g2_id = 0, g2_exp = 0, v2_count = 0;
   logic          v2_seen = 1'b0;
   logic [RW-1:0] v2_mod;
   logic          v2_id;

   logic [N*DW-1:0] xv, yv;

   task automatic clear_logs();
      g_cyc.delete(); g_id.delete(); v_cyc.delete(); v_id.delete(); v_mod.delete();
   endtask

   task automatic rnd_xy();
      for (int i = 0; i < N; i++) begin
         xv[i*DW +: DW] = DW'($urandom);
         yv[i*DW +: DW] = DW'($urandom);
      end
   endtask

   task automatic step(input logic rst, input logic [N-1:0] r);
      int w;
      @(negedge clock);
      cyc++;
      reset    = rst;
      bif.req  = r;
      bif.x_in = xv;
      bif.y_in = yv;

      if (bif.r2p_start === 1'b1) begin
         s_due = cyc + L;
         s_mod = stub_mod(bif.r2p_x, bif.r2p_y);
         s_ang = stub_ang(oh2id(8'(bif.gnt)));
      end
      bif.r2p_mod   = (cyc == s_due) ? s_mod : RW'($urandom);
      bif.r2p_angle = (cyc == s_due) ? s_ang : RW'($urandom);

      if (bif.gnt != '0) begin g_cyc.push_back(cyc); g_id.push_back(oh2id(8'(bif.gnt))); end
      if (bif.out_valid === 1'b1) begin
         v_cyc.push_back(cyc); v_id.push_back(int'(bif.out_id)); v_mod.push_back(bif.out_mod);
      end

      if (m_on) begin
         if (cyc == m_start) begin e_x = p_x; e_y = p_y; end
         if (cyc == m_done) begin e_id = p_id; e_mod = p_mod; e_ang = p_ang; end
         chk("gnt",       64'(bif.gnt),       (cyc == m_start) ? 64'(1) << p_id : 64'(0));
         chk("r2p_start", 64'(bif.r2p_start), 64'(cyc == m_start));
         chk("out_valid", 64'(bif.out_valid), 64'(cyc == m_done));
         chk("r2p_x",     64'(bif.r2p_x),     64'(e_x));
         chk("r2p_y",     64'(bif.r2p_y),     64'(e_y));
         chk("out_id",    64'(bif.out_id),    64'(e_id));
         chk("out_mod",   64'(bif.out_mod),   64'(e_mod));
         chk("out_angle", 64'(bif.out_angle), 64'(e_ang));
         chk("busy",      64'(bif.busy),      64'(!(cyc == m_arb && cyc != m_done)));
      end

      if (rst) begin
         m_on = 1'b1; m_arb = cyc + 1; m_ptr = 0; m_start = -1; m_done = -1;
         e_x = '0; e_y = '0; e_id = 0; e_mod = '0; e_ang = '0;
      end else if (m_on && cyc == m_arb) begin
         if (r != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            p_id    = w;
            p_x     = xv[w*DW +: DW];
            p_y     = yv[w*DW +: DW];
            p_mod   = stub_mod(p_x, p_y);
            p_ang   = stub_ang(w);
            m_start = cyc + 1;
            m_done  = cyc + 2 + L;
            m_arb   = m_done;
            m_ptr   = (w + 1) % N;
         end else begin
            m_arb = cyc + 1;
         end
      end

      // short-latency instance: both requesters held high after its reset
      reset2     = (cyc <= 2);
      bif2.req   = (cyc <= 2) ? 2'b00 : 2'b11;
      bif2.x_in  = (2*DW)'($urandom);
      bif2.y_in  = (2*DW)'($urandom);
      if (bif2.r2p_start === 1'b1) begin
         s2_due = cyc + L2;
         s2_mod = stub_mod(bif2.r2p_x, bif2.r2p_y);
         s2_ang = stub_ang(oh2id(8'(bif2.gnt)));
      end
      bif2.r2p_mod   = (cyc == s2_due) ? s2_mod : RW'($urandom);
      bif2.r2p_angle = (cyc == s2_due) ? s2_ang : RW'($urandom);
      if (cyc >= 3) begin
         if (bif2.out_valid === 1'b1) begin
            v2_count++;
            chk("l5_valid_after_gnt", 64'(cyc - g2_last), 64'(L2 + 1));
            chk("l5_out_id",  64'(bif2.out_id),  64'(g2_id));
            chk("l5_out_mod", 64'(bif2.out_mod), 64'(s2_mod));
            v2_seen = 1'b1; v2_mod = bif2.out_mod; v2_id = bif2.out_id;
         end else if (v2_seen) begin
            chk("l5_mod_hold", 64'(bif2.out_mod), 64'(v2_mod));
            chk("l5_id_hold",  64'(bif2.out_id),  64'(v2_id));
         end
         if (bif2.gnt != '0) begin
            if (g2_last >= 0) chk("l5_gnt_gap", 64'(cyc - g2_last), 64'(L2 + 2));
            chk("l5_gnt_id", 64'(oh2id(8'(bif2.gnt))), 64'(g2_exp));
            g2_id   = oh2id(8'(bif2.gnt));
            g2_exp  = 1 - g2_exp;
            g2_last = cyc;
         end
      end
   endtask

   initial begin
      int t0, t1;
      logic [N-1:0] r;
      xv = '0; yv = '0;
      bif.req = '0; bif.x_in = '0; bif.y_in = '0; bif.r2p_mod = '0; bif.r2p_angle = '0;
      bif2.req = '0; bif2.x_in = '0; bif2.y_in = '0; bif2.r2p_mod = '0; bif2.r2p_angle = '0;

      step(1'b1, '0); step(1'b1, '0); step(1'b0, '0); step(1'b0, '0);

      // single request, x=3 y=4
      clear_logs();
      xv[0 +: DW] = DW'(3); yv[0 +: DW] = DW'(4);
      t0 = cyc + 1;
      step(1'b0, 4'b0001);
      repeat (50) step(1'b0, '0);
      chk("single_gnt_count", 64'(g_cyc.size()), 64'(1));
      chk("single_gnt_at",    64'(qget(g_cyc, 0) - t0), 64'(1));
      chk("single_valid_at",  64'(qget(v_cyc, 0) - t0), 64'(35));
      chk("single_out_id",    64'(qget(v_id, 0)), 64'(0));
      chk("single_out_mod",   64'(v_mod.size() > 0 ? v_mod[0] : '1), 64'(7));

      // contention, req=1011 held from pointer 0
      step(1'b1, '0);
      rnd_xy();
      clear_logs();
      repeat (140) step(1'b0, 4'b1011);
      repeat (40) step(1'b0, '0);
      chk("cont_gnt_count", 64'(g_cyc.size()), 64'(4));
      chk("cont_gnt0", 64'(qget(g_id, 0)), 64'(0));
      chk("cont_gnt1", 64'(qget(g_id, 1)), 64'(1));
      chk("cont_gnt2", 64'(qget(g_id, 2)), 64'(3));
      chk("cont_gnt3", 64'(qget(g_id, 3)), 64'(0));
      for (int i = 1; i < 4; i++) chk("cont_gnt_gap", 64'(qget(g_cyc, i) - qget(g_cyc, i - 1)), 64'(35));
      chk("cont_id_seq", {32'(qget(v_id, 0)), 32'(qget(v_id, 1))}, {32'd0, 32'd1});
      chk("cont_id_seq2", {32'(qget(v_id, 2)), 32'(qget(v_id, 3))}, {32'd3, 32'd0});

      // pointer wrap: serve 3, then 1001 -> 0 then 3
      step(1'b1, '0);
      clear_logs();
      step(1'b0, 4'b1000);
      repeat (40) step(1'b0, '0);
      repeat (36) step(1'b0, 4'b1001);
      repeat (40) step(1'b0, '0);
      chk("wrap_count", 64'(g_id.size()), 64'(3));
      chk("wrap_seq", {32'(qget(g_id, 0)), 32'(qget(g_id, 1)), 32'(qget(g_id, 2))}, {32'd3, 32'd0, 32'd3});

      // reset 10 cycles after r2p_start of id 2
      step(1'b1, '0);
      clear_logs();
      step(1'b0, 4'b0100);
      repeat (10) step(1'b0, '0);
      step(1'b1, '0);
      repeat (40) step(1'b0, '0);
      chk("rst_gnt_count",   64'(g_id.size()), 64'(1));
      chk("rst_no_valid",    64'(v_cyc.size()), 64'(0));
      clear_logs();
      t1 = cyc + 1;
      step(1'b0, 4'b0100);
      repeat (40) step(1'b0, '0);
      chk("rst_regrant_at", 64'(qget(g_cyc, 0) - t1), 64'(1));
      chk("rst_regrant_id", 64'(qget(g_id, 0)), 64'(2));

      // withdrawal: req[1] raised during RUN, dropped before DONE
      clear_logs();
      step(1'b0, 4'b0001);
      repeat (5) step(1'b0, '0);
      repeat (10) step(1'b0, 4'b0010);
      repeat (40) step(1'b0, '0);
      chk("wd_gnt_count", 64'(g_id.size()), 64'(1));
      chk("wd_gnt_id",    64'(qget(g_id, 0)), 64'(0));
      chk("wd_valid",     64'(v_cyc.size()), 64'(1));

      // randomized traffic with occasional reset
      repeat (3000) begin
         rnd_xy();
         r = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
         step($urandom_range(0, 299) == 0, r);
      end

      chk("l5_strobes_seen", 64'(v2_count >= 400), 64'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
